bf_run_controller: RTL

//  Load/run sequencer for the brainfuck core. Takes a program as a byte stream,

---
 rtl/bf_run_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bf_run_controller.sv
// Load/run sequencer for the brainfuck core: streams a program into code RAM,
// zeroes array RAM, then releases the core and hands both RAM ports over to it.
module bf_run_controller #(
  parameter int addrSize_code  = 9,
  parameter int addrSize_array = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      abort,
  output logic [addrSize_code-1:0]  code_addr,
  output logic [7:0]                code_wdata,
  output logic                      code_we,
  output logic [addrSize_array-1:0] array_addr,
  output logic [7:0]                array_wdata,
  output logic                      array_we,
  input  logic [addrSize_code-1:0]  core_addr_code,
  input  logic [addrSize_array-1:0] core_addr_array,
  input  logic [7:0]                core_dataOut_array,
  input  logic                      core_writeRq_array,
  input  logic                      core_done,
  output logic                      core_reset_n,
  output logic                      core_receivingChar,
  output logic                      busy,
  output logic                      run_done,
  output logic                      overflow,
  output logic [addrSize_code:0]    load_len
);

  localparam logic [addrSize_code-1:0]  CODE_LAST  = '1;
  localparam logic [addrSize_array-1:0] ARRAY_LAST = '1;
  localparam logic [addrSize_code:0]    CODE_SIZE  = {1'b1, {addrSize_code{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [addrSize_code-1:0]  ptr_q, ptr_d;
  logic                      load_end_q, load_end_d;
  logic                      code_we_q, code_we_d;
  logic [addrSize_code-1:0]  code_addr_q, code_addr_d;
  logic [7:0]                code_wdata_q, code_wdata_d;
  logic                      array_we_q, array_we_d;
  logic [addrSize_array-1:0] array_addr_q, array_addr_d;
  logic                      overflow_q, overflow_d;
  logic [addrSize_code:0]    load_len_q, load_len_d;

  logic                      accept;
  logic [addrSize_code-1:0]  cur_ptr;
  logic                      is_term;
  logic                      at_last;
  logic                      run_phase;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      load_end_q   <= 1'b0;
      code_we_q    <= 1'b0;
      code_addr_q  <= '0;
      code_wdata_q <= '0;
      array_we_q   <= 1'b0;
      array_addr_q <= '0;
      overflow_q   <= 1'b0;
      load_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_end_q   <= load_end_d;
      code_we_q    <= code_we_d;
      code_addr_q  <= code_addr_d;
      code_wdata_q <= code_wdata_d;
      array_we_q   <= array_we_d;
      array_addr_q <= array_addr_d;
      overflow_q   <= overflow_d;
      load_len_q   <= load_len_d;
    end
  end

  // A byte starting a load (IDLE/DONE) always lands at address 0. load_end_q
  // marks the cycle the final code write is visible; no more bytes are taken.
  always_comb begin
    cur_ptr = (state_q == S_LOAD) ? ptr_q : '0;
    is_term = (rx_data == 8'h00);
    at_last = (cur_ptr == CODE_LAST);
    accept  = rx_valid && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                           ((state_q == S_LOAD) && !load_end_q));
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_end_d   = 1'b0;
    code_we_d    = 1'b0;
    code_addr_d  = code_addr_q;
    code_wdata_d = code_wdata_q;
    array_we_d   = 1'b0;
    array_addr_d = array_addr_q;
    overflow_d   = overflow_q;
    load_len_d   = load_len_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (rx_valid) begin
            state_d    = S_LOAD;
            overflow_d = 1'b0;
          end
        end
        S_LOAD: begin
          if (load_end_q) begin
            state_d      = S_CLEAR;
            array_we_d   = 1'b1;
            array_addr_d = '0;
          end
        end
        S_CLEAR: begin
          if (array_addr_q == ARRAY_LAST) begin
            state_d = S_RUN;
          end else begin
            array_we_d   = 1'b1;
            array_addr_d = array_addr_q + addrSize_array'(1);
          end
        end
        S_RUN: begin
          if (core_done) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase

      if (accept) begin
        code_we_d    = 1'b1;
        code_addr_d  = cur_ptr;
        code_wdata_d = (at_last && !is_term) ? 8'h00 : rx_data;
        ptr_d        = cur_ptr + addrSize_code'(1);
        if (is_term) begin
          load_end_d = 1'b1;
          load_len_d = {1'b0, cur_ptr} + (addrSize_code + 1)'(1);
        end else if (at_last) begin
          load_end_d = 1'b1;
          overflow_d = 1'b1;
          load_len_d = CODE_SIZE;
        end
      end
    end
  end

  // RUN/DONE hand the RAM ports to the core; otherwise the controller drives them.
  always_comb begin
    run_phase          = (state_q == S_RUN) || (state_q == S_DONE);
    code_addr          = run_phase ? core_addr_code : code_addr_q;
    code_we            = run_phase ? 1'b0 : code_we_q;
    code_wdata         = code_wdata_q;
    array_addr         = run_phase ? core_addr_array : array_addr_q;
    array_wdata        = run_phase ? core_dataOut_array : 8'h00;
    array_we           = run_phase ? core_writeRq_array : array_we_q;
    core_reset_n       = run_phase;
    core_receivingChar = rx_valid && (state_q == S_RUN);
    busy               = (state_q == S_LOAD) || (state_q == S_CLEAR);
    run_done           = (state_q == S_DONE);
    overflow           = overflow_q;
    load_len           = load_len_q;
  end

endmodule
